ex_stage_mdu: RTL
=================

EX_STAGE_MDU -- requirements
Module: ex_stage_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have port clk  in  1  clock, rising edge.
REQ-003 SHALL have port srst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc_e  in  XLEN  PC of the E-stage instruction.
REQ-005 SHALL have port pc_plus4_e  in  XLEN  PC+4 of the E-stage instruction.
REQ-006 SHALL have port rd1_e  in  XLEN  register operand A.
REQ-007 SHALL have port rd2_e  in  XLEN  register operand B.
REQ-008 SHALL have port imm_ext_e  in  XLEN  sign-extended immediate.
REQ-009 SHALL have port rd_e  in  5  destination register.
REQ-010 SHALL have port result_w  in  XLEN  W-stage forward value.
REQ-011 SHALL have port fwd_alu_m  in  XLEN  M-stage forward value.
REQ-012 SHALL have port forward_a_e  in  2  operand A forward select.
REQ-013 SHALL have port forward_b_e  in  2  operand B forward select.
REQ-014 SHALL have port reg_write_e  in  1  register write enable.
REQ-015 SHALL have port result_src_e  in  2  result source select.
REQ-016 SHALL have port mem_write_e  in  1  memory write enable.
REQ-017 SHALL have port jump_e  in  1  JAL or JALR.
REQ-018 SHALL have port jalr_e  in  1  JALR (qualifies jump_e).
REQ-019 SHALL have port branch_e  in  1  conditional branch.
REQ-020 SHALL have port funct3_e  in  3  branch condition or MDU opcode.
REQ-021 SHALL have port alu_control_e  in  4  ALU opcode.
REQ-022 SHALL have port alu_src_e  in  1  select immediate as operand B.
REQ-023 SHALL have port md_e  in  1  M-extension instruction.
REQ-024 SHALL have port stall_e  out  1  MDU busy; hazard unit holds F, D and E.
REQ-025 SHALL have port pc_src_e  out  1  redirect fetch.
REQ-026 SHALL have port pc_target_e  out  XLEN  redirect address.
REQ-027 SHALL have port pc_plus4_m, rd_m, alu_result_m, write_data_m  out  XLEN, 5, XLEN, XLEN  E/M register data.
REQ-028 SHALL have port result_src_m, mem_write_m, reg_write_m  out  2, 1, 1  E/M register control.

Function
REQ-029 SHALL select each operand by forward_x_e: 00 rdx_e, 01 result_w, 10 fwd_alu_m, 11 rdx_e; operand B SHALL then be imm_ext_e when alu_src_e=1, and write data SHALL be forwarded B before the immediate mux.
REQ-030 SHALL implement alu_control_e as: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass-B; shift amount is B[log2(XLEN)-1:0]; other codes return 0.
REQ-031 SHALL compute the branch condition from forwarded A and B by funct3_e: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010 and 011 are never taken.
REQ-032 SHALL drive pc_src_e = jump_e | (branch_e & cond) combinationally, with md_e instructions never asserting it.
REQ-033 SHALL drive pc_target_e = (A+imm)&~1 when jalr_e=1, else pc_e+imm_ext_e.
REQ-034 SHALL implement the MDU FSM IDLE->BUSY->DONE->IDLE, with opcodes from funct3_e: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-035 SHALL, in IDLE with md_e=1, capture the forwarded operands, assert stall_e combinationally, and enter BUSY with count=0.
REQ-036 SHALL run one shift-add or restoring-divide iteration per BUSY cycle on magnitudes, with stall_e=1, entering DONE after XLEN iterations.
REQ-037 SHALL, in DONE, hold stall_e=0, apply the sign correction, load the result into the E/M register, and return to IDLE unconditionally without re-capturing.
REQ-038 SHALL, as a consequence of REQ-035..037, hold stall_e high for exactly XLEN+1 cycles, with the result in alu_result_m after the (XLEN+2)th edge.
REQ-039 SHALL load a bubble into the E/M register while stall_e=1: reg_write_m, mem_write_m, result_src_m, rd_m, and all data outputs 0.
REQ-040 SHALL handle divide by zero as quotient all-ones and remainder equal to the dividend.
REQ-041 SHALL handle signed overflow (min / -1) as quotient equal to the dividend and remainder 0.
REQ-042 SHALL otherwise register all E-stage fields into the E/M register every cycle, with alu_result_m taking the ALU or MDU result.

Reset
REQ-043 SHALL, while srst=1 at a clock edge, clear all E/M outputs to 0, force the FSM to IDLE, clear the count, and hold stall_e=0 from the next cycle, including when reset arrives mid-operation.

Verification
REQ-044 SHALL verify: forward_a=10, fwd_alu_m=7, rd2_e=3, alu add -> alu_result_m=10 after one edge.
REQ-045 SHALL verify: A=0xFFFFFFFF, B=1, pc_e=0x100, imm=0x20: funct3=100 -> pc_src_e=1 with pc_target_e=0x120; funct3=110 -> pc_src_e=0.
REQ-046 SHALL verify: jalr with A=0x1003 and imm=4 -> pc_target_e=0x1006 and pc_src_e=1.
REQ-047 SHALL verify: mul and mulh on 0xFFFFFFFE and 3 -> 0xFFFFFFFA and 0xFFFFFFFF, with stall_e high for 33 cycles and bubbles in M during the stall.
REQ-048 SHALL verify: div 7/0 -> 0xFFFFFFFF; rem 7/0 -> 7; div 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-049 SHALL verify: srst asserted at BUSY count 10 -> stall_e=0 and all M outputs 0 on the next cycle, followed by correct completion of a fresh mul.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, an iterative
// multiply/divide unit, and the E/M pipeline register.
module ex_stage_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            srst,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [4:0]      rd_e,
  input  logic [XLEN-1:0] result_w,
  input  logic [XLEN-1:0] fwd_alu_m,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic            reg_write_e,
  input  logic [1:0]      result_src_e,
  input  logic            mem_write_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic            branch_e,
  input  logic [2:0]      funct3_e,
  input  logic [3:0]      alu_control_e,
  input  logic            alu_src_e,
  input  logic            md_e,
  output logic            stall_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [1:0]      result_src_m,
  output logic            mem_write_m,
  output logic            reg_write_m
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, jalr_sum;
  logic            cond;

  // Iterative MDU state; mcand/prod serve multiply, rem/quo/dvsr serve divide.
  logic [2:0]        op_p1;
  logic              a_neg_p1, b_neg_p1, div_zero_p1, ovf_p1;
  logic [XLEN-1:0]   dividend_p1, mplr_p1, rem_p1, quo_p1, dvsr_p1;
  logic [2*XLEN-1:0] mcand_p1, prod_p1, prod_s;
  logic [XLEN-1:0]   mdu_res, mag_a, mag_b;
  logic              a_sgn, b_sgn, a_neg_c, b_neg_c;
  logic [XLEN:0]     rem_sh, rem_sub;
  logic              fits;

  function automatic logic [XLEN-1:0] neg_w(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic n, input logic [2*XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] ctl,
                                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (ctl)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd6:    return {{(XLEN-1){1'b0}}, (a < b)};
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return $signed(a) >>> sh;
      4'd10:   return b;
      default: return '0;
    endcase
  endfunction

  function automatic logic br_cond(input logic [2:0] f3,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    case (forward_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = fwd_alu_m;
      default: src_a = rd1_e;
    endcase
    case (forward_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = fwd_alu_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b       = alu_src_e ? imm_ext_e : fwd_b;
  assign alu_res     = alu_op(alu_control_e, src_a, src_b);
  assign cond        = br_cond(funct3_e, src_a, fwd_b);
  assign pc_src_e    = ~md_e & (jump_e | (branch_e & cond));
  assign jalr_sum    = src_a + imm_ext_e;
  assign pc_target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : pc_e + imm_ext_e;
  assign stall_e     = ((state == IDLE) && md_e) || (state == BUSY);

  // Signed ops work on magnitudes; the sign is reapplied in DONE.
  assign a_sgn   = (funct3_e == 3'd1) || (funct3_e == 3'd2) || (funct3_e == 3'd4) || (funct3_e == 3'd6);
  assign b_sgn   = (funct3_e == 3'd1) || (funct3_e == 3'd4) || (funct3_e == 3'd6);
  assign a_neg_c = a_sgn & src_a[XLEN-1];
  assign b_neg_c = b_sgn & fwd_b[XLEN-1];
  assign mag_a   = neg_w(a_neg_c, src_a);
  assign mag_b   = neg_w(b_neg_c, fwd_b);

  assign rem_sh  = {rem_p1, quo_p1[XLEN-1]};
  assign rem_sub = rem_sh - {1'b0, dvsr_p1};
  assign fits    = rem_sh >= {1'b0, dvsr_p1};

  always_comb begin
    mdu_res = '0;
    prod_s  = neg_dw(a_neg_p1 ^ b_neg_p1, prod_p1);
    case (op_p1)
      3'd0:             mdu_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: mdu_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       mdu_res = div_zero_p1 ? '1 :
                                  ovf_p1 ? dividend_p1 : neg_w(a_neg_p1 ^ b_neg_p1, quo_p1);
      default:          mdu_res = div_zero_p1 ? dividend_p1 :
                                  ovf_p1 ? '0 : neg_w(a_neg_p1, rem_p1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (md_e) begin
          state <= BUSY;
          cnt   <= '0;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MDU datapath: capture at IDLE, one shift-add / restoring step per BUSY cycle
  always_ff @(posedge clk) begin
    if ((state == IDLE) && md_e) begin
      op_p1       <= funct3_e;
      a_neg_p1    <= a_neg_c;
      b_neg_p1    <= b_neg_c;
      dividend_p1 <= src_a;
      div_zero_p1 <= (fwd_b == '0);
      ovf_p1      <= ((funct3_e == 3'd4) || (funct3_e == 3'd6)) && (src_a == MIN_NEG) && (fwd_b == '1);
      prod_p1     <= '0;
      mcand_p1    <= {{XLEN{1'b0}}, mag_a};
      mplr_p1     <= mag_b;
      rem_p1      <= '0;
      quo_p1      <= mag_a;
      dvsr_p1     <= mag_b;
    end else if (state == BUSY) begin
      if (mplr_p1[0]) prod_p1 <= prod_p1 + mcand_p1;
      mcand_p1 <= mcand_p1 << 1;
      mplr_p1  <= mplr_p1 >> 1;
      rem_p1   <= fits ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_p1   <= {quo_p1[XLEN-2:0], fits};
    end
  end

  // E/M register: bubble while the MDU holds the front of the pipe
  always_ff @(posedge clk) begin
    if (srst || stall_e) begin
      pc_plus4_m   <= '0;
      rd_m         <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      result_src_m <= '0;
      mem_write_m  <= 1'b0;
      reg_write_m  <= 1'b0;
    end else begin
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
      alu_result_m <= (state == DONE) ? mdu_res : alu_res;
      write_data_m <= fwd_b;
      result_src_m <= result_src_e;
      mem_write_m  <= mem_write_e;
      reg_write_m  <= reg_write_e;
    end
  end

endmodule
